// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: single-stream dispatcher in front of a 1-to-4 demux.
// Each accepted word goes to its explicit destination or to the next enabled
// channel in round-robin order. It is then held in a one-entry output register
// until the selected channel takes it.
// Optional feature macro: DEMUX_CNT_EN adds per-channel saturating transfer
// counters on the xfer_cnt port.
module demux_dispatch_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_auto,
    input  logic [1:0]        in_dest,
    input  logic [3:0]        ch_en,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              drop
`ifdef DEMUX_CNT_EN
    ,
    output logic [4*CNT_W-1:0] xfer_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [1:0]        dst_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        rr_ptr;
    logic              drop_q;

    logic [1:0]        auto_dst;
    logic [1:0]        sel_dst;
    logic [1:0]        scan_idx;
    logic              scan_found;
    logic              accept;
    logic              load;
    logic              drop_now;
    logic              deliver;

    // Round-robin search: first enabled channel starting at rr_ptr, wrapping mod 4
    always_comb begin
        auto_dst   = rr_ptr;
        scan_found = 1'b0;
        scan_idx   = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr + 2'(i);
            if (!scan_found && ch_en[scan_idx]) begin
                auto_dst   = scan_idx;
                scan_found = 1'b1;
            end
        end
    end

    // Handshake, destination choice, and next-state decision
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        sel_dst    = in_auto ? auto_dst : in_dest;
        deliver    = (state == BUSY) && out_ready[dst_q];

        if (rst_n && ((state == IDLE) || deliver) && !(in_auto && (ch_en == 4'b0000))) begin
            in_ready = 1'b1;
        end

        accept   = in_valid && in_ready;
        load     = accept && ch_en[sel_dst];
        drop_now = accept && !in_auto && !ch_en[in_dest];

        if (load) begin
            next_state = BUSY;
        end else if (deliver) begin
            next_state = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Output buffer, round-robin pointer and drop pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_q  <= 2'd0;
            data_q <= '0;
            rr_ptr <= 2'd0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_now;
            if (load) begin
                dst_q  <= sel_dst;
                data_q <= in_data;
            end
            if (accept && in_auto) begin
                rr_ptr <= auto_dst + 2'd1;
            end
        end
    end

    // One-hot valid toward the channel holding the buffered word
    always_comb begin
        out_valid = 4'b0000;
        if (state == BUSY) begin
            out_valid[dst_q] = 1'b1;
        end
    end

    assign out_data = data_q;
    assign drop     = drop_q;

`ifdef DEMUX_CNT_EN
    logic [3:0][CNT_W-1:0] cnt_q;

    // Per-channel completed-transfer counters that stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl: directed self-checking bench for demux_dispatch_ctrl.
// Uses a narrow counter width so that saturation can be reached quickly when
// DEMUX_CNT_EN is defined.
module tb_demux_dispatch_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_auto;
    logic [1:0]        in_dest;
    logic [3:0]        ch_en;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [DATA_W-1:0] out_data;
    logic              drop;
`ifdef DEMUX_CNT_EN
    logic [4*CNT_W-1:0] xfer_cnt;
`endif

    int test_count = 0;
    int fail_count = 0;

    demux_dispatch_ctrl #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_auto   (in_auto),
        .in_dest   (in_dest),
        .ch_en     (ch_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop      (drop)
`ifdef DEMUX_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic auto_sel, input logic [1:0] dest,
                                 input logic [7:0] data, input logic [3:0] en, input logic [3:0] ordy);
        in_valid  = valid;
        in_auto   = auto_sel;
        in_dest   = dest;
        in_data   = data;
        ch_en     = en;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_expect [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 4'hF);
        #1;
        checkOutput("reset in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_data", 32'(out_data), 32'd0);
        checkOutput("reset drop", 32'(drop), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("release in_ready", 32'(in_ready), 32'd1);

        // Explicit routing to channel 2
        applyStimulus(1'b1, 1'b0, 2'd2, 8'hA5, 4'hF, 4'hF);
        #1;
        checkOutput("t2 in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("t2 out_valid", 32'(out_valid), 32'b0100);
        checkOutput("t2 out_data", 32'(out_data), 32'hA5);
        in_valid = 1'b0;
        tick();
        checkOutput("t2 drained", 32'(out_valid), 32'd0);

        // Backpressure on channel 1; other channels' ready must be ignored
        applyStimulus(1'b1, 1'b0, 2'd1, 8'h3C, 4'hF, 4'b1101);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd1, 8'h77, 4'hF, 4'b1101);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("t3 held valid", 32'(out_valid), 32'b0010);
            checkOutput("t3 held data", 32'(out_data), 32'h3C);
            checkOutput("t3 in_ready low", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 4'hF;
        #1;
        checkOutput("t3 in_ready raise", 32'(in_ready), 32'd1);
        tick();
        checkOutput("t3 reload valid", 32'(out_valid), 32'b0010);
        checkOutput("t3 reload data", 32'(out_data), 32'h77);
        in_valid = 1'b0;
        tick();
        checkOutput("t3 drained", 32'(out_valid), 32'd0);

        // Round-robin over mask 1011, back to back
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd2, 8'(8'h10 + i), 4'b1011, 4'hF);
            #1;
            checkOutput("t4 in_ready", 32'(in_ready), 32'd1);
            tick();
            checkOutput("t4 rr dest", 32'(out_valid), 32'(4'b0001 << rr_expect[i]));
            checkOutput("t4 rr data", 32'(out_data), 32'(8'h10 + i));
        end
        in_valid = 1'b0;
        tick();
        checkOutput("t4 drained", 32'(out_valid), 32'd0);

        // Explicit word to a disabled channel is swallowed with a drop pulse
        applyStimulus(1'b1, 1'b0, 2'd0, 8'hEE, 4'b1110, 4'hF);
        #1;
        checkOutput("t5 in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("t5 drop pulse", 32'(drop), 32'd1);
        checkOutput("t5 no valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t5 drop clear", 32'(drop), 32'd0);
        checkOutput("t5 still idle", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 2'd0, 8'h11, 4'b0000, 4'hF);
        #1;
        checkOutput("t5 auto no en", 32'(in_ready), 32'd0);
        tick();
        checkOutput("t5 auto no accept", 32'(out_valid), 32'd0);

        // Reset while a word is pending
        applyStimulus(1'b1, 1'b0, 2'd2, 8'h5A, 4'hF, 4'h0);
        tick();
        in_valid = 1'b0;
        checkOutput("t1 busy valid", 32'(out_valid), 32'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t1 rst valid", 32'(out_valid), 32'd0);
        checkOutput("t1 rst data", 32'(out_data), 32'd0);
        checkOutput("t1 rst in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("t1 release ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("t1 word lost", 32'(out_valid), 32'd0);

        // After reset the round-robin pointer restarts at channel 0
        applyStimulus(1'b1, 1'b1, 2'd3, 8'h42, 4'hF, 4'hF);
        tick();
        in_valid = 1'b0;
        checkOutput("t1 rr restart", 32'(out_valid), 32'b0001);
        tick();

`ifdef DEMUX_CNT_EN
        // Counters: three transfers to ch3, one to ch0 (counters were cleared by reset above,
        // then one ch0 transfer just completed)
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 2'd3, 8'(i), 4'hF, 4'hF);
            tick();
        end
        in_valid = 1'b0;
        tick();
        checkOutput("t6 cnt ch0", 32'(xfer_cnt[0*CNT_W +: CNT_W]), 32'd1);
        checkOutput("t6 cnt ch1", 32'(xfer_cnt[1*CNT_W +: CNT_W]), 32'd0);
        checkOutput("t6 cnt ch2", 32'(xfer_cnt[2*CNT_W +: CNT_W]), 32'd0);
        checkOutput("t6 cnt ch3", 32'(xfer_cnt[3*CNT_W +: CNT_W]), 32'd3);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 2'd3, 8'(i), 4'hF, 4'hF);
            tick();
        end
        in_valid = 1'b0;
        tick();
        checkOutput("t6 cnt ch3 sat", 32'(xfer_cnt[3*CNT_W +: CNT_W]), 32'd15);
        checkOutput("t6 cnt ch0 hold", 32'(xfer_cnt[0*CNT_W +: CNT_W]), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
